mux_scan_sequencer: RTL
=======================

Name: mux_scan_sequencer

Overview:
Upstream control stage for the 10-to-1 channel multiplexer. It generates the 4-bit channel select, stepping through the enabled channels 0..9 and holding each one for a programmable dwell time. It runs single-shot or continuous frames, flags each frame end, and can optionally capture the multiplexer's output bit per channel into a frame word.

Parameters:
- NUM_CH, 10, number of mux channels; legal range 2..16.
- SEL_W, 4, select width; must satisfy 2**SEL_W >= NUM_CH.
- DWELL, 4, clock cycles each channel is held on sel; must be >= 1.

Ports:
- clk  in  1  single system clock; all logic is on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- en  in  1  dwell-count enable; when low, the sequencer freezes in place.
- start  in  1  begins a frame from IDLE.
- abort  in  1  terminates scanning and returns to IDLE.
- cont  in  1  continuous mode; sampled when start is accepted.
- ch_mask  in  NUM_CH  per-channel enable; bit i=1 means channel i is scanned. Latched when start is accepted.
- mux_x  in  1  mux output bit, fed back from the mux; used only with the optional feature.
- sel  out  SEL_W  registered channel select to the mux.
- sel_valid  out  1  high while sel addresses a live channel.
- busy  out  1  high in SCAN.
- frame_done  out  1  one-cycle pulse at the end of each frame.
- frame_data  out  NUM_CH  captured channel bits; present only with the optional feature.

Behaviour:
- Reset values: state=IDLE, sel=0, sel_valid=0, busy=0, frame_done=0, dwell counter=0, latched mask=0, latched mode=0, frame_data=0.
- All outputs are registered; there is no combinational input-to-output path.
- FSM states are IDLE and SCAN.
- IDLE, start=1 and ch_mask!=0:
  - Latch ch_mask and cont.
  - Next cycle: state=SCAN, sel=lowest set mask bit, sel_valid=1, busy=1, dwell=0.
- IDLE, start=1 and ch_mask==0: start is ignored and the block stays IDLE with no pulse.
- SCAN, en=1: dwell increments each cycle.
- SCAN, en=1 and dwell==DWELL-1: dwell returns to 0, and sel moves to the next higher set bit of the latched mask.
  - If no higher bit is set, this is the end of the frame: frame_done=1 for exactly one cycle, coincident with the sel update.
  - Continuous mode at frame end: sel wraps to the lowest set bit and scanning continues without a gap.
  - Single-shot mode at frame end: state=IDLE, sel=0, sel_valid=0, busy=0.
- SCAN, en=0: dwell, sel and sel_valid all hold.
- Latency: each channel is presented for exactly DWELL enabled cycles. DWELL=1 steps the channel every enabled cycle.
- Masked channels are never driven on sel. sel never exceeds NUM_CH-1.
- A mask with a single bit set: in continuous mode sel stays constant and frame_done pulses every DWELL enabled cycles.
- start while in SCAN: ignored, and changes to ch_mask/cont take no effect until the next accepted start.
- abort=1 in any state: the next cycle is IDLE with sel=0, sel_valid=0, busy=0, and no frame_done pulse.
  - abort takes priority over frame end and over start.
- Asserting rst_n low mid-frame forces the reset values immediately, without waiting for a clock edge.

Optional Feature:
- Macro name: MUX_SCAN_CAPTURE_EN.
- Defined:
  - On the last dwell cycle of each channel (en=1, dwell==DWELL-1), mux_x is written into shadow bit [sel].
  - The shadow register is cleared when start is accepted and at each frame wrap. Masked bits therefore read 0.
  - frame_data is loaded from the shadow, including the bit being captured in that same cycle, on the cycle frame_done is asserted.
  - frame_data holds its value between frames.
- Not defined: the frame_data port, the shadow register and all capture logic are absent; mux_x is unused.

Decomposition:
- Package mux_scan_pkg:
  - state enum type (IDLE, SCAN);
  - default NUM_CH/SEL_W constants;
  - function next_set_bit(mask, from) returning the index and a found flag.
- One sub-module, mux_scan_chfind: combinational priority finder returning the lowest set mask bit above a given index, plus a wrap flag. It is instantiated once for advance and once for first/wrap with from=-1.

Test Plan:
- Reset then idle: rst_n low for 3 cycles, then release with no start → sel=0, sel_valid=0, busy=0, frame_done never pulses.
- Full single-shot frame:
  - Stimulus: ch_mask=10'h3FF, DWELL=4, cont=0, en=1, start pulse.
  - Required: sel steps 0..9 with 4 cycles each; frame_done pulses once, 40 cycles after the first sel_valid; then IDLE.
- Sparse continuous frame:
  - Stimulus: ch_mask=10'b10_0001_0010, cont=1.
  - Required: sel sequence 1,4,9,1,4,9…; frame_done pulses on each 9→1 wrap.
- en gap and abort:
  - Stimulus: drop en for 5 cycles mid-dwell on channel 3.
  - Required: sel holds at 3 and the channel still totals 4 enabled cycles. Then assert abort in the same cycle as frame end → IDLE, no frame_done.
- Zero mask and start during SCAN: start with ch_mask=0 → stays IDLE. A second start while in SCAN does not restart the frame or relatch the mask.
- Capture (MUX_SCAN_CAPTURE_EN):
  - Stimulus: drive mux_x = channel index parity, mask=10'h3FF.
  - Required: frame_data=10'b10_1010_1010 at frame_done. With mask=10'h00F, bits 9..4 read 0.

Source files
------------

// File: rtl/mux_scan_sequencer_pkg.sv
// Shared types and helpers for the mux scan sequencer (mux_scan_pkg).
// Channel search is written for up to MAX_CH channels and narrowed by callers.
package mux_scan_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_e;

    localparam int DEF_NUM_CH = 10;
    localparam int DEF_SEL_W  = 4;
    localparam int MAX_CH     = 16;

    typedef struct packed {
        logic       found;
        logic [3:0] idx;
    } find_t;

    // Lowest set bit strictly above 'from'; from = -1 yields the lowest set bit overall.
    function automatic find_t next_set_bit(input logic [MAX_CH-1:0] mask, input int from);
        find_t r;
        r.found = 1'b0;
        r.idx   = 4'd0;
        for (int i = MAX_CH - 1; i >= 0; i--) begin
            if ((i > from) && mask[i]) begin
                r.found = 1'b1;
                r.idx   = 4'(i);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/mux_scan_sequencer_if.sv
// Control/status bundle between a scan controller and the mux scan sequencer.
// frame_data exists only when MUX_SCAN_CAPTURE_EN is defined.
interface mux_scan_sequencer_if
    import mux_scan_pkg::*;
#(
    parameter int NUM_CH = DEF_NUM_CH,
    parameter int SEL_W  = DEF_SEL_W
);
    logic              en;
    logic              start;
    logic              abort;
    logic              cont;
    logic [NUM_CH-1:0] ch_mask;
    logic              mux_x;
    logic [SEL_W-1:0]  sel;
    logic              sel_valid;
    logic              busy;
    logic              frame_done;
`ifdef MUX_SCAN_CAPTURE_EN
    logic [NUM_CH-1:0] frame_data;

    modport master (
        output en, start, abort, cont, ch_mask, mux_x,
        input  sel, sel_valid, busy, frame_done, frame_data
    );

    modport slave (
        input  en, start, abort, cont, ch_mask, mux_x,
        output sel, sel_valid, busy, frame_done, frame_data
    );
`else
    modport master (
        output en, start, abort, cont, ch_mask, mux_x,
        input  sel, sel_valid, busy, frame_done
    );

    modport slave (
        input  en, start, abort, cont, ch_mask, mux_x,
        output sel, sel_valid, busy, frame_done
    );
`endif
endinterface

// File: rtl/mux_scan_sequencer_chfind.sv
// Combinational priority finder: lowest set mask bit above from_i.
// wrap_o is high when no such bit exists (end of frame, or empty mask when from_i = -1).
module mux_scan_chfind
    import mux_scan_pkg::*;
#(
    parameter int NUM_CH = DEF_NUM_CH,
    parameter int SEL_W  = DEF_SEL_W
) (
    input  logic [NUM_CH-1:0]       mask_i,
    input  logic signed [SEL_W:0]   from_i,
    output logic [SEL_W-1:0]        idx_o,
    output logic                    wrap_o
);

    find_t hit;

    always_comb begin
        hit    = next_set_bit(MAX_CH'(mask_i), int'(from_i));
        idx_o  = SEL_W'(hit.idx);
        wrap_o = ~hit.found;
    end

endmodule

// File: rtl/mux_scan_sequencer.sv
// Channel-select sequencer for the 10:1 mux: dwell-timed scan over enabled channels.
// Define MUX_SCAN_CAPTURE_EN to capture mux_x per channel into frame_data.
//
// state | meaning
// IDLE  | sel parked at 0, waiting for start with a non-empty mask
// SCAN  | presenting latched-mask channels, DWELL enabled cycles each
module mux_scan_sequencer
    import mux_scan_pkg::*;
#(
    parameter int NUM_CH = DEF_NUM_CH,
    parameter int SEL_W  = DEF_SEL_W,
    parameter int DWELL  = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    mux_scan_sequencer_if.slave bus
);

    localparam int DW_W = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [DW_W-1:0] DWELL_LAST = DW_W'(DWELL - 1);
    localparam logic signed [SEL_W:0] FROM_NONE = '1;

    state_e            state_q, state_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic              sel_valid_q, sel_valid_d;
    logic              busy_q, busy_d;
    logic              frame_done_q, frame_done_d;
    logic [DW_W-1:0]   dwell_q, dwell_d;
    logic [NUM_CH-1:0] mask_q, mask_d;
    logic              cont_q, cont_d;

    logic [NUM_CH-1:0]     first_mask;
    logic signed [SEL_W:0] adv_from;
    logic [SEL_W-1:0]      adv_idx, first_idx;
    logic                  adv_wrap, first_wrap;
    logic                  last_dwell;
    logic                  start_ok;

    // In IDLE the first-channel finder looks at the live mask so SCAN can open on it directly.
    assign first_mask = (state_q == IDLE) ? bus.ch_mask : mask_q;
    assign adv_from   = {1'b0, sel_q};
    assign last_dwell = bus.en && (dwell_q == DWELL_LAST);
    assign start_ok   = (state_q == IDLE) && bus.start && !first_wrap && !bus.abort;

    mux_scan_chfind #(.NUM_CH(NUM_CH), .SEL_W(SEL_W)) u_find_adv (
        .mask_i (mask_q),
        .from_i (adv_from),
        .idx_o  (adv_idx),
        .wrap_o (adv_wrap)
    );

    mux_scan_chfind #(.NUM_CH(NUM_CH), .SEL_W(SEL_W)) u_find_first (
        .mask_i (first_mask),
        .from_i (FROM_NONE),
        .idx_o  (first_idx),
        .wrap_o (first_wrap)
    );

    always_comb begin
        state_d      = state_q;
        sel_d        = sel_q;
        sel_valid_d  = sel_valid_q;
        busy_d       = busy_q;
        frame_done_d = 1'b0;
        dwell_d      = dwell_q;
        mask_d       = mask_q;
        cont_d       = cont_q;

        if (bus.abort) begin
            state_d     = IDLE;
            sel_d       = '0;
            sel_valid_d = 1'b0;
            busy_d      = 1'b0;
            dwell_d     = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_ok) begin
                        mask_d      = bus.ch_mask;
                        cont_d      = bus.cont;
                        state_d     = SCAN;
                        sel_d       = first_idx;
                        sel_valid_d = 1'b1;
                        busy_d      = 1'b1;
                        dwell_d     = '0;
                    end
                end
                SCAN: begin
                    if (bus.en) begin
                        if (last_dwell) begin
                            dwell_d = '0;
                            if (!adv_wrap) begin
                                sel_d = adv_idx;
                            end else begin
                                frame_done_d = 1'b1;
                                if (cont_q) begin
                                    sel_d = first_idx;
                                end else begin
                                    state_d     = IDLE;
                                    sel_d       = '0;
                                    sel_valid_d = 1'b0;
                                    busy_d      = 1'b0;
                                end
                            end
                        end else begin
                            dwell_d = dwell_q + 1'b1;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            sel_q        <= '0;
            sel_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            dwell_q      <= '0;
            mask_q       <= '0;
            cont_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            sel_q        <= sel_d;
            sel_valid_q  <= sel_valid_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
            dwell_q      <= dwell_d;
            mask_q       <= mask_d;
            cont_q       <= cont_d;
        end
    end

    assign bus.sel        = sel_q;
    assign bus.sel_valid  = sel_valid_q;
    assign bus.busy       = busy_q;
    assign bus.frame_done = frame_done_q;

`ifdef MUX_SCAN_CAPTURE_EN
    logic [NUM_CH-1:0] shadow_q, shadow_d;
    logic [NUM_CH-1:0] shadow_cap;
    logic [NUM_CH-1:0] frame_data_q, frame_data_d;

    // Each channel is visited once per frame and the shadow starts cleared, so OR-in is a write.
    assign shadow_cap = shadow_q | (NUM_CH'(bus.mux_x) << sel_q);

    always_comb begin
        shadow_d     = shadow_q;
        frame_data_d = frame_data_q;
        if (start_ok) begin
            shadow_d = '0;
        end else if ((state_q == SCAN) && last_dwell && !bus.abort) begin
            shadow_d = shadow_cap;
            if (adv_wrap) begin
                frame_data_d = shadow_cap;
                shadow_d     = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_q     <= '0;
            frame_data_q <= '0;
        end else begin
            shadow_q     <= shadow_d;
            frame_data_q <= frame_data_d;
        end
    end

    assign bus.frame_data = frame_data_q;
`else
    logic unused_mux_x;
    assign unused_mux_x = bus.mux_x;
`endif

endmodule
